// File: rtl/cam_pkg.sv
// Shared constants and FSM state type for the DVP camera capture block.
package cam_pkg;

    localparam int unsigned PIX_W    = 16;
    localparam int unsigned CNT_W    = 12;
    localparam int unsigned DEF_IN_W = 1280;
    localparam int unsigned DEF_IN_H = 720;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SKIP   = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs stage-1 DVP bytes into RGB565 pixels (high byte first) and flags lines
// that end on an unpaired byte.
module cam_byte_pack
    import cam_pkg::*;
(
    input  logic             wr0_clk,
    input  logic             wr0_rst_n,
    input  logic             href_i,
    input  logic             href_prev_i,
    input  logic [7:0]       data_i,
    input  logic             abort_i,
    output logic             pix_vld_o,
    output logic [PIX_W-1:0] pix_o,
    output logic             odd_o
);

    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic             vld_q, vld_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             odd_q, odd_d;
    logic             href_rise, href_fall;

    assign href_rise = href_i & ~href_prev_i;
    assign href_fall = ~href_i & href_prev_i;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        pix_d   = pix_q;
        vld_d   = 1'b0;
        odd_d   = 1'b0;
        if (abort_i) begin
            // the byte in flight belongs to a torn line; drop it
            phase_d = 1'b0;
        end else if (href_i) begin
            if (href_rise || !phase_q) begin
                hi_d    = data_i;
                phase_d = 1'b1;
            end else begin
                pix_d   = {hi_q, data_i};
                vld_d   = 1'b1;
                phase_d = 1'b0;
            end
        end else begin
            phase_d = 1'b0;
            odd_d   = href_fall & phase_q;
        end
    end

    always_ff @(posedge wr0_clk or negedge wr0_rst_n) begin
        if (!wr0_rst_n) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
            odd_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            pix_q   <= pix_d;
            vld_q   <= vld_d;
            odd_q   <= odd_d;
        end
    end

    assign pix_vld_o = vld_q;
    assign pix_o     = pix_q;
    assign odd_o     = odd_q;

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP camera capture: frame-skip FSM, geometry checking and RGB565 output stream.
// Optional CAM_CAPTURE_STATS_EN adds meas_w/meas_h measured-geometry outputs.
module cam_dvp_capture
    import cam_pkg::*;
#(
    parameter int unsigned IN_W        = DEF_IN_W,
    parameter int unsigned IN_H        = DEF_IN_H,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic             wr0_clk,
    input  logic             wr0_rst_n,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    input  logic             cap_en,
    output logic             out_vs,
    output logic             out_href,
    output logic             out_de,
    output logic [PIX_W-1:0] out_data,
    output logic             frame_done,
    output logic             line_err
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [CNT_W-1:0] meas_w,
    output logic [CNT_W-1:0] meas_h
`endif
);

    localparam logic [CNT_W-1:0] W_REQ  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] H_REQ  = CNT_W'(IN_H);
    localparam logic [7:0]       SKIP_N = 8'(SKIP_FRAMES);

    logic             s1_vs_q, s1_hr_q;
    logic [7:0]       s1_d_q;
    logic             s2_vs_q, s2_hr_q;
    logic             s3_vs_q, s3_hr_q;

    cap_state_e       state_q, state_d;
    logic [7:0]       skip_q, skip_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             err_q, err_d;
    logic             fd_q, fd_d;
    logic             out_vs_q, out_hr_q, out_de_q;
    logic [PIX_W-1:0] out_data_q;
`ifdef CAM_CAPTURE_STATS_EN
    logic [CNT_W-1:0] meas_w_q, meas_w_d;
    logic [CNT_W-1:0] meas_h_q, meas_h_d;
`endif

    logic             pk_vld, pk_odd;
    logic [PIX_W-1:0] pk_pix;
    logic             vs1_rise, vs2_rise, hr2_fall;
    logic             act, pix_de;

    // Pairing runs on stage 1; frame/line bookkeeping runs one stage later so
    // the last pixel of a line is already counted when its href fall is seen.
    assign vs1_rise = s1_vs_q & ~s2_vs_q;
    assign vs2_rise = s2_vs_q & ~s3_vs_q;
    assign hr2_fall = ~s2_hr_q & s3_hr_q;
    assign act      = (state_q == ST_ACTIVE);
    assign pix_de   = pk_vld & (state_d == ST_ACTIVE);

    cam_byte_pack u_pack (
        .wr0_clk     (wr0_clk),
        .wr0_rst_n   (wr0_rst_n),
        .href_i      (s1_hr_q),
        .href_prev_i (s2_hr_q),
        .data_i      (s1_d_q),
        .abort_i     (vs1_rise & s1_hr_q),
        .pix_vld_o   (pk_vld),
        .pix_o       (pk_pix),
        .odd_o       (pk_odd)
    );

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (vs2_rise) begin
            unique case (state_q)
                ST_IDLE: begin
                    skip_d = '0;
                    if (cap_en) state_d = (SKIP_N == 8'd0) ? ST_ACTIVE : ST_SKIP;
                end
                ST_SKIP: begin
                    if (!cap_en) begin
                        state_d = ST_IDLE;
                        skip_d  = '0;
                    end else if (skip_q + 8'd1 == SKIP_N) begin
                        state_d = ST_ACTIVE;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + 8'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (!cap_en) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        err_d      = err_q;
        fd_d       = 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
        meas_w_d   = meas_w_q;
        meas_h_d   = meas_h_q;
`endif
        if (pix_de) pix_cnt_d = sat_inc(pix_cnt_q);
        if (act && hr2_fall) begin
            if (pix_cnt_q != W_REQ || pk_odd) err_d = 1'b1;
            line_cnt_d = sat_inc(line_cnt_q);
            pix_cnt_d  = '0;
`ifdef CAM_CAPTURE_STATS_EN
            meas_w_d   = pix_cnt_q;
`endif
        end
        if (act && vs2_rise) begin
            if (line_cnt_q != H_REQ || s2_hr_q) err_d = 1'b1;
            fd_d       = (line_cnt_q != '0);
            line_cnt_d = '0;
            pix_cnt_d  = '0;
`ifdef CAM_CAPTURE_STATS_EN
            meas_h_d   = line_cnt_q;
`endif
        end
    end

    always_ff @(posedge wr0_clk or negedge wr0_rst_n) begin
        if (!wr0_rst_n) begin
            s1_vs_q    <= 1'b0;
            s1_hr_q    <= 1'b0;
            s1_d_q     <= '0;
            s2_vs_q    <= 1'b0;
            s2_hr_q    <= 1'b0;
            s3_vs_q    <= 1'b0;
            s3_hr_q    <= 1'b0;
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            err_q      <= 1'b0;
            fd_q       <= 1'b0;
            out_vs_q   <= 1'b0;
            out_hr_q   <= 1'b0;
            out_de_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            s1_vs_q    <= cam_vsync;
            s1_hr_q    <= cam_href;
            s1_d_q     <= cam_data;
            s2_vs_q    <= s1_vs_q;
            s2_hr_q    <= s1_hr_q;
            s3_vs_q    <= s2_vs_q;
            s3_hr_q    <= s2_hr_q;
            state_q    <= state_d;
            skip_q     <= skip_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            err_q      <= err_d;
            fd_q       <= fd_d;
            out_vs_q   <= (state_d == ST_ACTIVE) & s2_vs_q;
            out_hr_q   <= (state_d == ST_ACTIVE) & s2_hr_q;
            out_de_q   <= pix_de;
            if (pix_de) out_data_q <= pk_pix;
        end
    end

`ifdef CAM_CAPTURE_STATS_EN
    always_ff @(posedge wr0_clk or negedge wr0_rst_n) begin
        if (!wr0_rst_n) begin
            meas_w_q <= '0;
            meas_h_q <= '0;
        end else begin
            meas_w_q <= meas_w_d;
            meas_h_q <= meas_h_d;
        end
    end

    assign meas_w = meas_w_q;
    assign meas_h = meas_h_q;
`endif

    assign out_vs     = out_vs_q;
    assign out_href   = out_hr_q;
    assign out_de     = out_de_q;
    assign out_data   = out_data_q;
    assign frame_done = fd_q;
    assign line_err   = err_q;

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture on a reduced 4x3 geometry with two skip frames.
module tb_cam_dvp_capture;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned SK = 2;

    logic        wr0_clk = 1'b0;
    logic        wr0_rst_n;
    logic        cam_vsync, cam_href, cap_en;
    logic [7:0]  cam_data;
    logic        out_vs, out_href, out_de, frame_done, line_err;
    logic [15:0] out_data;
`ifdef CAM_CAPTURE_STATS_EN
    logic [11:0] meas_w, meas_h;
`endif

    cam_dvp_capture #(.IN_W(W), .IN_H(H), .SKIP_FRAMES(SK)) dut (
        .wr0_clk    (wr0_clk),
        .wr0_rst_n  (wr0_rst_n),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .cap_en     (cap_en),
        .out_vs     (out_vs),
        .out_href   (out_href),
        .out_de     (out_de),
        .out_data   (out_data),
        .frame_done (frame_done),
        .line_err   (line_err)
`ifdef CAM_CAPTURE_STATS_EN
        ,
        .meas_w     (meas_w),
        .meas_h     (meas_h)
`endif
    );

    always #5 wr0_clk = ~wr0_clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: monotonic event counters sampled on the falling edge.
    int unsigned cyc = 0;
    int unsigned de_cnt = 0, fd_cnt = 0, vs_cnt = 0, cov_err = 0, line_de = 0;
    int unsigned last_de_cyc = 0, err_rise_cyc = 0;
    logic [15:0] last_pix = '0, first_pix = '0;
    logic        err_prev = 1'b0;

    always @(posedge wr0_clk) cyc <= cyc + 1;

    always @(negedge wr0_clk) begin
        if (out_de) begin
            de_cnt++;
            last_de_cyc = cyc;
            last_pix    = out_data;
            if (line_de == 0) first_pix = out_data;
            line_de++;
            if (!out_href) cov_err++;
        end
        if (!out_href) line_de = 0;
        if (frame_done) fd_cnt++;
        if (out_vs) vs_cnt++;
        if (line_err && !err_prev) err_rise_cyc = cyc;
        err_prev = line_err;
    end

    int unsigned lo_cyc = 0, fall_cyc = 0, odd_fall = 0;

    task automatic idle(input int n);
        repeat (n) @(negedge wr0_clk);
    endtask

    task automatic send_line(input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge wr0_clk);
            cam_href = 1'b1;
            if (i == nb - 2)      cam_data = 8'hF8;
            else if (i == nb - 1) cam_data = 8'h1F;
            else                  cam_data = 8'(8'h30 + i);
            if (i == nb - 1) lo_cyc = cyc + 1;
        end
        @(negedge wr0_clk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        fall_cyc = cyc + 1;
        idle(3);
    endtask

    task automatic vs_pulse();
        @(negedge wr0_clk) cam_vsync = 1'b1;
        @(negedge wr0_clk);
        @(negedge wr0_clk) cam_vsync = 1'b0;
        idle(2);
    endtask

    task automatic send_frame(input int nl, input int odd_idx, input int drop_idx);
        vs_pulse();
        for (int l = 0; l < nl; l++) begin
            if (l == drop_idx) cap_en = 1'b0;
            send_line((l == odd_idx) ? int'(2 * W - 1) : int'(2 * W));
            if (l == odd_idx) odd_fall = fall_cyc;
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s_de, s_fd, s_vs;
        wr0_rst_n = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        cap_en    = 1'b0;
        idle(3);
        check_eq("rst_vs",   {31'd0, out_vs},     32'd0);
        check_eq("rst_href", {31'd0, out_href},   32'd0);
        check_eq("rst_de",   {31'd0, out_de},     32'd0);
        check_eq("rst_data", {16'd0, out_data},   32'd0);
        check_eq("rst_fd",   {31'd0, frame_done}, 32'd0);
        check_eq("rst_err",  {31'd0, line_err},   32'd0);
        @(negedge wr0_clk) wr0_rst_n = 1'b1;
        idle(2);
        cap_en = 1'b1;

        // two settling frames, then the first emitted frame
        s_de = de_cnt; s_vs = vs_cnt;
        send_frame(H, -1, -1);
        send_frame(H, -1, -1);
        idle(4);
        check_eq("skip_de", de_cnt - s_de, 32'd0);
        check_eq("skip_vs", vs_cnt - s_vs, 32'd0);

        s_de = de_cnt; s_fd = fd_cnt; s_vs = vs_cnt;
        send_frame(H, -1, -1);
        idle(4);
        check_eq("frame_de",  de_cnt - s_de, W * H);
        check_eq("frame_vs",  vs_cnt - s_vs, 32'd2);
        check_eq("frame_fd0", fd_cnt - s_fd, 32'd0);
        check_eq("frame_err", {31'd0, line_err}, 32'd0);
        check_eq("first_pix", {16'd0, first_pix}, 32'h3031);
        check_eq("last_pix",  {16'd0, last_pix},  32'hF81F);
        check_eq("de_lat",    last_de_cyc - lo_cyc, 32'd2);

        // middle line one byte short
        s_de = de_cnt; s_fd = fd_cnt;
        send_frame(H, 1, -1);
        idle(4);
        check_eq("prev_fd",  fd_cnt - s_fd, 32'd1);
        check_eq("odd_de",   de_cnt - s_de, W * H - 1);
        check_eq("odd_err",  {31'd0, line_err}, 32'd1);
        check_eq("err_lat",  err_rise_cyc - odd_fall, 32'd2);
        check_eq("odd_tail", {16'd0, last_pix}, 32'hF81F);
`ifdef CAM_CAPTURE_STATS_EN
        check_eq("meas_w", {20'd0, meas_w}, W);
`endif

        // reset pulse in the middle of a line
        vs_pulse();
        for (int i = 0; i < 3; i++) begin
            @(negedge wr0_clk);
            cam_href = 1'b1;
            cam_data = 8'(8'h50 + i);
        end
        @(negedge wr0_clk);
        wr0_rst_n = 1'b0;
        #1;
        check_eq("mrst_vs",   {31'd0, out_vs},     32'd0);
        check_eq("mrst_href", {31'd0, out_href},   32'd0);
        check_eq("mrst_de",   {31'd0, out_de},     32'd0);
        check_eq("mrst_data", {16'd0, out_data},   32'd0);
        check_eq("mrst_err",  {31'd0, line_err},   32'd0);
        s_de = de_cnt;
        @(negedge wr0_clk) wr0_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr0_clk);
            cam_data = 8'(8'h60 + i);
        end
        @(negedge wr0_clk) cam_href = 1'b0;
        idle(3);
        send_frame(H, -1, -1);
        send_frame(H, -1, -1);
        idle(4);
        check_eq("rst_skip_de", de_cnt - s_de, 32'd0);

        // short frame: two lines only
        s_de = de_cnt;
        send_frame(H - 1, -1, -1);
        idle(4);
        check_eq("short_de",  de_cnt - s_de, W * (H - 1));
        check_eq("short_err0", {31'd0, line_err}, 32'd0);

        // next frame exposes the short one; cap_en drops during it
        s_de = de_cnt; s_fd = fd_cnt; s_vs = vs_cnt;
        send_frame(H, -1, 1);
        idle(4);
        check_eq("short_fd",  fd_cnt - s_fd, 32'd1);
        check_eq("short_err", {31'd0, line_err}, 32'd1);
        check_eq("drop_de",   de_cnt - s_de, W * H);
        check_eq("drop_vs",   vs_cnt - s_vs, 32'd2);
`ifdef CAM_CAPTURE_STATS_EN
        check_eq("meas_h", {20'd0, meas_h}, H - 1);
`endif

        s_de = de_cnt; s_fd = fd_cnt; s_vs = vs_cnt;
        send_frame(H, -1, -1);
        idle(4);
        check_eq("idle_fd",  fd_cnt - s_fd, 32'd1);
        check_eq("idle_de",  de_cnt - s_de, 32'd0);
        check_eq("idle_vs",  vs_cnt - s_vs, 32'd0);
        check_eq("href_cov", cov_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
